// File: rtl/irq_arbiter_if.sv
// Interrupt request bundle between the event/CPU side and the arbiter.
interface irq_arbiter_if #(
  parameter int unsigned ID_W = 2
) ();
  localparam int unsigned NUM_SRC = 1 << ID_W;

  logic [NUM_SRC-1:0] ExtIrq;
  logic [NUM_SRC-1:0] IrqEnable;
  logic               IrqAck;
  logic               IrqReq;
  logic [ID_W-1:0]    IrqId;
  logic [NUM_SRC-1:0] IrqPending;

  // Board events and CPU side
  modport master (
    output ExtIrq,
    output IrqEnable,
    output IrqAck,
    input  IrqReq,
    input  IrqId,
    input  IrqPending
  );

  // Arbiter side
  modport slave (
    input  ExtIrq,
    input  IrqEnable,
    input  IrqAck,
    output IrqReq,
    output IrqId,
    output IrqPending
  );
endinterface

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronizes and edge-detects asynchronous event lines, latches them as
// pending, and hands enabled pending sources to the CPU one at a time with round-robin priority
// over a req/ack handshake. ID_W must match the ID_W of the connected interface instance.
module irq_arbiter #(
  parameter int unsigned ID_W = 2
) (
  input  logic         Clock,
  input  logic         Reset,
  irq_arbiter_if.slave bus
);

  localparam int unsigned NUM_SRC = 1 << ID_W;

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e             state_q;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] edge_det, eligible, ack_clear;
  logic               req_q;
  logic [ID_W-1:0]    id_q, last_id_q;
  logic [ID_W-1:0]    winner, cand;
  logic               hit;

  // Two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= bus.ExtIrq;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Pending next-state: a new edge wins over the ack-clear of the same source
  always_comb begin
    edge_det  = sync2_q & ~prev_q;
    eligible  = pending_q & bus.IrqEnable;
    ack_clear = '0;
    if (state_q == StReq && bus.IrqAck) begin
      ack_clear[id_q] = 1'b1;
    end
    pending_d = (pending_q & ~ack_clear) | edge_det;
  end

  // Round-robin search starting just above the last serviced source
  always_comb begin
    winner = '0;
    cand   = '0;
    hit    = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      // Offset NUM_SRC wraps to zero, so the last serviced source is tried last
      cand = last_id_q + ID_W'(k);
      if (!hit && eligible[cand]) begin
        winner = cand;
        hit    = 1'b1;
      end
    end
  end

  // Pending vector register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Grant FSM with registered request, id and round-robin pointer
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      id_q      <= '0;
      last_id_q <= '1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit) begin
            id_q    <= winner;
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          // Enable changes are ignored here; only the ack ends the request
          if (bus.IrqAck) begin
            last_id_q <= id_q;
            req_q     <= 1'b0;
            state_q   <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.IrqReq     = req_q;
  assign bus.IrqId      = id_q;
  assign bus.IrqPending = pending_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios plus a randomized run against a reference model
// built from the sampled input history and a round-robin scan.
module tb_irq_arbiter;
  localparam int unsigned ID_W = 2;
  localparam int unsigned N    = 1 << ID_W;

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  irq_arbiter_if #(.ID_W(ID_W)) bus ();

  irq_arbiter #(.ID_W(ID_W)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Reference model: history of ExtIrq samples (newest first) and the grant bookkeeping
  logic [N-1:0] hist[$];
  logic [N-1:0] m_pend;
  bit           m_busy;
  int           m_id;
  int           m_last;

  task automatic model_reset();
    logic [N-1:0] z;
    z = '0;
    hist.delete();
    repeat (4) hist.push_front(z);
    m_pend = '0;
    m_busy = 1'b0;
    m_id   = 0;
    m_last = N - 1;
  endtask

  // Advance one clock; the model consumes the inputs present just before the edge
  task automatic step();
    logic [N-1:0] smp, en, setb, nxt;
    bit ack, found;
    int idx;
    smp = bus.ExtIrq;
    en  = bus.IrqEnable;
    ack = bus.IrqAck;
    @(posedge Clock);
    #1;
    if (Reset) begin
      hist.push_front(smp);
      void'(hist.pop_back());
      // An event reaches pending two samples after the line was first seen high
      setb = hist[2] & ~hist[3];
      nxt  = m_pend;
      if (m_busy && ack) nxt[m_id] = 1'b0;
      nxt = nxt | setb;
      if (m_busy) begin
        if (ack) begin
          m_busy = 1'b0;
          m_last = m_id;
        end
      end else begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!found && m_pend[idx] && en[idx]) begin
            found  = 1'b1;
            m_id   = idx;
            m_busy = 1'b1;
          end
        end
      end
      m_pend = nxt;
    end
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.IrqReq === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (bus.IrqReq === 1'b1) ok = 1'b1;
  endtask

  task automatic do_reset();
    Reset         = 1'b0;
    bus.ExtIrq    = '0;
    bus.IrqEnable = '0;
    bus.IrqAck    = 1'b0;
    model_reset();
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.ExtIrq    = '1;
    bus.IrqEnable = '1;
    bus.IrqAck    = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checks++; if (bus.IrqReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.IrqReq); end
    checks++; if (bus.IrqId !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.IrqId); end
    checks++; if (bus.IrqPending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", bus.IrqPending); end
  endtask

  task automatic test_single_event();
    do_reset();
    bus.IrqEnable = 4'hF;
    bus.ExtIrq    = 4'b0100;
    step(); step();
    checks++; if (bus.IrqPending !== 4'b0000) begin errors++; $display("FAIL single_early_pending: got %b want 0000", bus.IrqPending); end
    step();
    bus.ExtIrq = '0;
    checks++; if (bus.IrqPending !== 4'b0100) begin errors++; $display("FAIL single_pending_e2: got %b want 0100", bus.IrqPending); end
    checks++; if (bus.IrqReq !== 1'b0) begin errors++; $display("FAIL single_req_e2: got %b want 0", bus.IrqReq); end
    step();
    checks++; if (bus.IrqReq !== 1'b1) begin errors++; $display("FAIL single_req_e3: got %b want 1", bus.IrqReq); end
    checks++; if (bus.IrqId !== 2'd2) begin errors++; $display("FAIL single_id_e3: got %0d want 2", bus.IrqId); end
    bus.IrqAck = 1'b1;
    step();
    bus.IrqAck = 1'b0;
    checks++; if (bus.IrqReq !== 1'b0) begin errors++; $display("FAIL single_req_ack: got %b want 0", bus.IrqReq); end
    checks++; if (bus.IrqPending !== 4'b0000) begin errors++; $display("FAIL single_pending_ack: got %b want 0000", bus.IrqPending); end
    repeat (4) step();
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    bus.IrqEnable = 4'hF;
    bus.ExtIrq    = 4'hF;
    wait_req(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_first_req: got timeout want IrqReq=1"); end
    for (int g = 0; g < 4; g++) begin
      if (g > 0) begin
        step();
        checks++; if (bus.IrqReq !== 1'b1) begin errors++; $display("FAIL rr_req_%0d: got %b want 1", g, bus.IrqReq); end
      end
      checks++; if (bus.IrqId !== 2'(g)) begin errors++; $display("FAIL rr_id_%0d: got %0d want %0d", g, bus.IrqId, g); end
      step(); step();
      bus.IrqAck = 1'b1;
      step();
      bus.IrqAck = 1'b0;
      checks++; if (bus.IrqReq !== 1'b0) begin errors++; $display("FAIL rr_gap_%0d: got %b want 0", g, bus.IrqReq); end
    end
    checks++; if (bus.IrqPending !== 4'b0000) begin errors++; $display("FAIL rr_pending_end: got %b want 0000", bus.IrqPending); end
    bus.ExtIrq = '0;
    repeat (3) step();
  endtask

  task automatic test_enable_gating();
    do_reset();
    bus.IrqEnable = 4'b1101;
    bus.ExtIrq    = 4'b0010;
    repeat (3) step();
    bus.ExtIrq = '0;
    repeat (4) step();
    checks++; if (bus.IrqPending !== 4'b0010) begin errors++; $display("FAIL en_pending: got %b want 0010", bus.IrqPending); end
    checks++; if (bus.IrqReq !== 1'b0) begin errors++; $display("FAIL en_masked_req: got %b want 0", bus.IrqReq); end
    bus.IrqEnable = 4'hF;
    step();
    checks++; if (bus.IrqReq !== 1'b1) begin errors++; $display("FAIL en_req: got %b want 1", bus.IrqReq); end
    checks++; if (bus.IrqId !== 2'd1) begin errors++; $display("FAIL en_id: got %0d want 1", bus.IrqId); end
    bus.IrqEnable = 4'h0;
    repeat (2) step();
    checks++; if (bus.IrqReq !== 1'b1 || bus.IrqId !== 2'd1) begin errors++; $display("FAIL en_hold: got req=%b id=%0d want req=1 id=1", bus.IrqReq, bus.IrqId); end
    bus.IrqAck = 1'b1;
    step();
    bus.IrqAck = 1'b0;
    checks++; if (bus.IrqPending !== 4'b0000 || bus.IrqReq !== 1'b0) begin errors++; $display("FAIL en_ack: got req=%b pend=%b want req=0 pend=0000", bus.IrqReq, bus.IrqPending); end
    bus.IrqEnable = 4'hF;
  endtask

  task automatic test_set_wins_and_merge();
    int grants;
    do_reset();
    bus.IrqEnable = 4'hF;
    bus.ExtIrq    = 4'b1000;
    repeat (3) step();
    bus.ExtIrq = '0;
    step();
    checks++; if (bus.IrqReq !== 1'b1 || bus.IrqId !== 2'd3) begin errors++; $display("FAIL sw_first: got req=%b id=%0d want req=1 id=3", bus.IrqReq, bus.IrqId); end
    step();
    bus.ExtIrq = 4'b1000;
    step(); step();
    bus.IrqAck = 1'b1;
    step();
    bus.IrqAck = 1'b0;
    bus.ExtIrq = '0;
    checks++; if (bus.IrqReq !== 1'b0) begin errors++; $display("FAIL sw_req_ack: got %b want 0", bus.IrqReq); end
    checks++; if (bus.IrqPending !== 4'b1000) begin errors++; $display("FAIL sw_pending: got %b want 1000", bus.IrqPending); end
    step();
    checks++; if (bus.IrqReq !== 1'b1 || bus.IrqId !== 2'd3) begin errors++; $display("FAIL sw_second: got req=%b id=%0d want req=1 id=3", bus.IrqReq, bus.IrqId); end
    bus.IrqAck = 1'b1;
    step();
    bus.IrqAck = 1'b0;
    checks++; if (bus.IrqPending !== 4'b0000) begin errors++; $display("FAIL sw_clear: got %b want 0000", bus.IrqPending); end
    // Three pulses on source 0 while it is held disabled merge into one event
    bus.IrqEnable = 4'b1110;
    repeat (3) begin
      bus.ExtIrq = 4'b0001;
      repeat (2) step();
      bus.ExtIrq = '0;
      repeat (2) step();
    end
    repeat (3) step();
    checks++; if (bus.IrqPending !== 4'b0001 || bus.IrqReq !== 1'b0) begin errors++; $display("FAIL merge_pending: got req=%b pend=%b want req=0 pend=0001", bus.IrqReq, bus.IrqPending); end
    bus.IrqEnable = 4'hF;
    grants = 0;
    repeat (20) begin
      step();
      if (bus.IrqReq === 1'b1) begin
        if (bus.IrqId === 2'd0) grants++;
        bus.IrqAck = 1'b1;
        step();
        bus.IrqAck = 1'b0;
      end
    end
    checks++; if (grants != 1) begin errors++; $display("FAIL merge_grants: got %0d want 1", grants); end
  endtask

  task automatic test_reset_mid_handshake();
    int grants;
    int last_id;
    do_reset();
    bus.IrqEnable = 4'hF;
    bus.ExtIrq    = 4'b0011;
    repeat (4) step();
    checks++; if (bus.IrqReq !== 1'b1 || bus.IrqPending !== 4'b0011) begin errors++; $display("FAIL mid_setup: got req=%b pend=%b want req=1 pend=0011", bus.IrqReq, bus.IrqPending); end
    #2;
    Reset      = 1'b0;
    bus.ExtIrq = 4'b0010;
    model_reset();
    #1;
    checks++; if (bus.IrqReq !== 1'b0) begin errors++; $display("FAIL mid_req: got %b want 0", bus.IrqReq); end
    checks++; if (bus.IrqId !== 2'd0) begin errors++; $display("FAIL mid_id: got %0d want 0", bus.IrqId); end
    checks++; if (bus.IrqPending !== 4'b0000) begin errors++; $display("FAIL mid_pending: got %b want 0000", bus.IrqPending); end
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    step(); step();
    checks++; if (bus.IrqPending !== 4'b0000) begin errors++; $display("FAIL rel_early: got %b want 0000", bus.IrqPending); end
    step();
    checks++; if (bus.IrqPending !== 4'b0010) begin errors++; $display("FAIL rel_pending: got %b want 0010", bus.IrqPending); end
    grants  = 0;
    last_id = -1;
    repeat (20) begin
      step();
      if (bus.IrqReq === 1'b1) begin
        grants++;
        last_id = int'(bus.IrqId);
        bus.IrqAck = 1'b1;
        step();
        bus.IrqAck = 1'b0;
      end
    end
    checks++; if (grants != 1 || last_id != 1) begin errors++; $display("FAIL rel_grants: got %0d grants id %0d want 1 grant id 1", grants, last_id); end
    bus.IrqAck = 1'b1;
    step();
    bus.IrqAck = 1'b0;
    checks++; if (bus.IrqReq !== 1'b0 || bus.IrqPending !== 4'b0000 || bus.IrqId !== 2'd1) begin
      errors++; $display("FAIL spurious_ack: got req=%b pend=%b id=%0d want req=0 pend=0000 id=1", bus.IrqReq, bus.IrqPending, bus.IrqId);
    end
    bus.ExtIrq = '0;
    repeat (3) step();
  endtask

  task automatic test_random();
    logic [N-1:0] flip;
    do_reset();
    bus.IrqEnable = 4'hF;
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 3) == 0);
      bus.ExtIrq = bus.ExtIrq ^ flip;
      if ($urandom_range(0, 15) == 0) bus.IrqEnable = N'($urandom);
      bus.IrqAck = ($urandom_range(0, 2) == 0);
      step();
      checks++; if (bus.IrqReq !== m_busy) begin errors++; $display("FAIL rnd_req c%0d: got %b want %b", c, bus.IrqReq, m_busy); end
      if (m_busy) begin
        checks++; if (bus.IrqId !== 2'(m_id)) begin errors++; $display("FAIL rnd_id c%0d: got %0d want %0d", c, bus.IrqId, m_id); end
      end
      checks++; if (bus.IrqPending !== m_pend) begin errors++; $display("FAIL rnd_pending c%0d: got %b want %b", c, bus.IrqPending, m_pend); end
    end
    bus.IrqAck = 1'b0;
  endtask

  initial begin
    bus.ExtIrq    = '0;
    bus.IrqEnable = '0;
    bus.IrqAck    = 1'b0;
    model_reset();
    test_reset();
    test_single_event();
    test_round_robin();
    test_enable_gating();
    test_set_wins_and_merge();
    test_reset_mid_handshake();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before 500000");
    $fatal(1);
  end

endmodule
